// File: rtl/shift_decode.sv
// Decode stage feeding the barrel shifter: picks MIPS shift ops out of R-type beats.
// Optional SHIFT_DEC_ROTR_EN adds MIPS32r2 ROTR/ROTRV decode.
module shift_decode #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       sh,
   output logic [31:0]      amt_reg,
   output logic [31:0]      src,
   output logic             reg_imm,
   output logic             left_right,
   output logic             al,
   output logic             rot,
   output logic [4:0]       rd,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef struct packed {
      logic [4:0]  sh;
      logic [31:0] amt_reg;
      logic [31:0] src;
      logic        reg_imm;
      logic        left_right;
      logic        al;
      logic        rot;
      logic [4:0]  rd;
   } cmd_t;

   cmd_t       dec;
   cmd_t       m_q;
   cmd_t       s_q;
   logic       m_valid;
   logic       s_valid;
   logic       is_shift;
   logic       op_r;
   logic [5:0] funct;
   logic       f_sll;
   logic       f_srl;
   logic       f_sra;
   logic       f_sllv;
   logic       f_srlv;
   logic       f_srav;
   logic       acc;
   logic       acc_sh;
   logic       acc_drop;
   logic       m_fire;

   assign op_r   = (instr[31:26] == 6'd0);
   assign funct  = instr[5:0];
   assign f_sll  = (funct == 6'b000000);
   assign f_srl  = (funct == 6'b000010);
   assign f_sra  = (funct == 6'b000011);
   assign f_sllv = (funct == 6'b000100);
   assign f_srlv = (funct == 6'b000110);
   assign f_srav = (funct == 6'b000111);

   always_comb begin
      dec          = '0;
      dec.sh       = instr[10:6];
      dec.amt_reg  = rs_data;
      dec.src      = rt_data;
      dec.rd       = instr[15:11];
      is_shift     = 1'b0;
      if (op_r) begin
         unique case (1'b1)
            f_sll: begin
               is_shift       = 1'b1;
               dec.left_right = 1'b1;
            end
            f_srl: begin
               is_shift = 1'b1;
               dec.al   = 1'b1;
            end
            f_sra: begin
               is_shift = 1'b1;
            end
            f_sllv: begin
               is_shift       = 1'b1;
               dec.left_right = 1'b1;
               dec.reg_imm    = 1'b1;
            end
            f_srlv: begin
               is_shift    = 1'b1;
               dec.al      = 1'b1;
               dec.reg_imm = 1'b1;
            end
            f_srav: begin
               is_shift    = 1'b1;
               dec.reg_imm = 1'b1;
            end
            default: ;
         endcase
      end
`ifdef SHIFT_DEC_ROTR_EN
      // r2 rotates reuse the SRL/SRLV functs, flagged by a spare rs/sa bit
      dec.rot = op_r && ((f_srl && instr[21]) || (f_srlv && instr[6]));
`else
      dec.rot = 1'b0;
`endif
   end

   assign in_ready = !s_valid;
   assign acc      = in_valid && in_ready;
   assign acc_sh   = acc && is_shift;
   assign acc_drop = acc && !is_shift;
   assign m_fire   = m_valid && out_ready;

   // S only fills when M is held, so a full S never coincides with an accept
   always_ff @(posedge clk) begin
      if (rst) begin
         m_q     <= '0;
         s_q     <= '0;
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (m_fire && s_valid) begin
         m_q     <= s_q;
         s_valid <= 1'b0;
      end else if (acc_sh) begin
         if (!m_valid || m_fire) begin
            m_q     <= dec;
            m_valid <= 1'b1;
         end else begin
            s_q     <= dec;
            s_valid <= 1'b1;
         end
      end else if (m_fire) begin
         m_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (acc_drop && (drop_cnt != {CNT_W{1'b1}})) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign out_valid  = m_valid;
   assign sh         = m_q.sh;
   assign amt_reg    = m_q.amt_reg;
   assign src        = m_q.src;
   assign reg_imm    = m_q.reg_imm;
   assign left_right = m_q.left_right;
   assign al         = m_q.al;
   assign rot        = m_q.rot;
   assign rd         = m_q.rd;

endmodule

// File: tb/tb_shift_decode.sv
// Randomised bench for shift_decode against a queue-based reference model.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_shift_decode;

   typedef struct packed {
      logic [4:0]  sh;
      logic [31:0] amt;
      logic [31:0] src;
      logic        reg_imm;
      logic        lr;
      logic        al;
      logic        rot;
      logic [4:0]  rd;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  sh;
   logic [31:0] amt_reg;
   logic [31:0] src;
   logic        reg_imm;
   logic        left_right;
   logic        al;
   logic        rot;
   logic [4:0]  rd;
   logic [15:0] drop_cnt;

   logic        in_ready2;
   logic        out_valid2;
   logic [4:0]  sh2;
   logic [31:0] amt_reg2;
   logic [31:0] src2;
   logic        reg_imm2;
   logic        left_right2;
   logic        al2;
   logic        rot2;
   logic [4:0]  rd2;
   logic [1:0]  drop_cnt2;

   always #5 clk = ~clk;

   shift_decode u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
      .out_valid(out_valid), .out_ready(out_ready), .sh(sh),
      .amt_reg(amt_reg), .src(src), .reg_imm(reg_imm),
      .left_right(left_right), .al(al), .rot(rot), .rd(rd),
      .drop_cnt(drop_cnt)
   );

   shift_decode #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
      .out_valid(out_valid2), .out_ready(out_ready), .sh(sh2),
      .amt_reg(amt_reg2), .src(src2), .reg_imm(reg_imm2),
      .left_right(left_right2), .al(al2), .rot(rot2), .rd(rd2),
      .drop_cnt(drop_cnt2)
   );

   cmd_t obs;
   assign obs = {sh, amt_reg, src, reg_imm, left_right, al, rot, rd};

   int   n_chk  = 0;
   int   n_fail = 0;
   int   drop   = 0;
   cmd_t q[$];

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit shift_op(input logic [31:0] i);
      int f;
      f = int'(i[5:0]);
      return (i[31:26] == 6'd0) &&
             (f == 0 || f == 2 || f == 3 || f == 4 || f == 6 || f == 7);
   endfunction

   function automatic cmd_t model(input logic [31:0] i,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      cmd_t c;
      int   f;
      f         = int'(i[5:0]);
      c.sh      = i[10:6];
      c.amt     = a;
      c.src     = b;
      c.rd      = i[15:11];
      c.reg_imm = (f >= 4);
      c.lr      = (f == 0 || f == 4);
      c.al      = (f == 2 || f == 6);
`ifdef SHIFT_DEC_ROTR_EN
      c.rot     = (f == 2 && i[21]) || (f == 6 && i[6]);
`else
      c.rot     = 1'b0;
`endif
      return c;
   endfunction

   task automatic step(input logic v, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic r);
      bit fire;
      bit acc;
      rst       = r;
      in_valid  = v;
      instr     = i;
      rs_data   = a;
      rt_data   = b;
      out_ready = ordy;
      @(negedge clk);
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      check("drop_cnt", drop_cnt, drop);
      check("drop_cnt_sat", drop_cnt2, (drop > 3) ? 3 : drop);
      if (q.size() > 0) check("cmd", obs, q[0]);
      if (r) begin
         q.delete();
         drop = 0;
      end else begin
         fire = (q.size() > 0) && ordy;
         acc  = v && (q.size() < 2);
         if (fire) void'(q.pop_front());
         if (acc) begin
            if (shift_op(i)) q.push_back(model(i, a, b));
            else if (drop < 65535) drop++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
   endtask

   logic [5:0] fl [6] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      instr     = '0;
      rs_data   = '0;
      rt_data   = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("rst_outs", obs, '0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_ready", in_ready, 1'b1);

      step(1'b1, 32'h00021080, 32'h0, 32'h1, 1'b1, 1'b0);
      check("sll_valid", out_valid, 1'b1);
      check("sll_sh", sh, 5'd2);
      check("sll_lr", left_right, 1'b1);
      check("sll_ri", reg_imm, 1'b0);
      check("sll_src", src, 32'h1);
      check("sll_rd", rd, 5'd2);

      step(1'b1, 32'h00A41807, 32'h4, 32'h80000000, 1'b1, 1'b0);
      check("srav_al", al, 1'b0);
      check("srav_ri", reg_imm, 1'b1);
      check("srav_amt", amt_reg, 32'h4);
      check("srav_src", src, 32'h80000000);
      check("srav_rd", rd, 5'd3);
      idle(1'b1);

      step(1'b1, 32'h00011042, 32'h11, 32'hA1, 1'b0, 1'b0);
      step(1'b1, 32'h000118C2, 32'h22, 32'hA2, 1'b0, 1'b0);
      check("stall_ready", in_ready, 1'b0);
      step(1'b1, 32'h00012102, 32'h33, 32'hA3, 1'b0, 1'b0);
      check("stall_hold", rd, 5'd2);
      step(1'b1, 32'h00012102, 32'h33, 32'hA3, 1'b1, 1'b0);
      step(1'b1, 32'h00012102, 32'h33, 32'hA3, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) idle(1'b1);
      check("stall_drain", q.size(), 0);

      step(1'b1, 32'h00021080, 32'h0, 32'h5, 1'b1, 1'b0);
      step(1'b1, 32'h00851020, 32'h7, 32'h8, 1'b1, 1'b0);
      step(1'b1, 32'h000310C0, 32'h0, 32'h6, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      check("add_drop", drop_cnt, 16'd1);
      for (int k = 0; k < 5; k++)
         step(1'b1, 32'h00851020, 32'h0, 32'h0, 1'b1, 1'b0);
      idle(1'b1);
      check("sat_drop", drop_cnt2, 2'd3);
      check("wide_drop", drop_cnt, 16'd6);

      step(1'b1, 32'h00021080, 32'h1, 32'h2, 1'b0, 1'b0);
      step(1'b1, 32'h00031080, 32'h3, 32'h4, 1'b0, 1'b0);
      check("full_ready", in_ready, 1'b0);
      step(1'b1, 32'h00021080, 32'h9, 32'h9, 1'b0, 1'b1);
      check("rst2_valid", out_valid, 1'b0);
      check("rst2_ready", in_ready, 1'b1);
      check("rst2_outs", obs, '0);
      check("rst2_drop", drop_cnt, 16'd0);

      step(1'b1, 32'h00200A02, 32'h1, 32'hF0, 1'b1, 1'b0);
      check("rotr_sh", sh, 5'd8);
      check("rotr_al", al, 1'b1);
`ifdef SHIFT_DEC_ROTR_EN
      check("rotr_rot", rot, 1'b1);
`else
      check("rotr_rot", rot, 1'b0);
`endif
      idle(1'b1);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] w;
         int          sel;
         w   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel < 6) begin
            w[31:26] = 6'd0;
            w[5:0]   = fl[sel];
         end else if (sel == 6) begin
            w[31:26] = 6'd0;
         end
         step($urandom_range(0, 9) < 7, w, $urandom, $urandom,
              $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
      end
      for (int k = 0; k < 4; k++) idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
